// File: rtl/ram_line_server.sv
// rtl/ram_line_server.sv - single-outstanding line fill / write-back responder with programmable latency
module ram_line_server #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [0:31][7:0]  req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_we,
    output logic [0:31][7:0]  resp_rdata,
    output logic [31:0]       read_count,
    output logic [31:0]       write_count
);
    localparam int LINES = 1 << (ADDR_W - 5);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state_q;
    logic [7:0]          cnt_q;
    logic                req_ready_q;
    logic                resp_valid_q;
    logic                resp_we_q;
    logic [0:31][7:0]    buf_q;
    logic [31:0]         rd_cnt_q;
    logic [31:0]         wr_cnt_q;
    logic [0:31][7:0]    mem_q [0:LINES-1];
    logic [0:31][7:0]    addr_pat;
    logic [0:31][7:0]    mem_line;
    logic [ADDR_W-6:0]   line_idx;
    logic                accept;
    logic [4:0]          unused_offset;

    assign line_idx      = req_addr[ADDR_W-1:5];
    assign accept        = req_valid && req_ready_q;
    assign unused_offset = req_addr[4:0];

    // Storage holds data XOR the low byte of each byte address, so a zero
    // power-up array reads back as mem[a] = a[7:0] without an initialiser.
    always_comb begin
        addr_pat = '0;
        for (int k = 0; k < 32; k++) begin
            addr_pat[k] = 8'({line_idx, k[4:0]});
        end
    end

    assign mem_line = mem_q[line_idx] ^ addr_pat;

    always_ff @(posedge clk) begin
        if (accept && req_we) begin
            mem_q[line_idx] <= req_wdata ^ addr_pat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_we_q    <= 1'b0;
            buf_q        <= '0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q     <= S_WAIT;
                        cnt_q       <= 8'(LATENCY - 1);
                        req_ready_q <= 1'b0;
                        resp_we_q   <= req_we;
                        buf_q       <= req_we ? req_wdata : mem_line;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 8'd0) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state_q      <= S_IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        if (resp_we_q) begin
                            wr_cnt_q <= wr_cnt_q + 32'd1;
                        end else begin
                            rd_cnt_q <= rd_cnt_q + 32'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_we     = resp_we_q;
    assign resp_rdata  = buf_q;
    assign read_count  = rd_cnt_q;
    assign write_count = wr_cnt_q;

endmodule

// File: tb/tb_ram_line_server.sv
// tb/tb_ram_line_server.sv - randomized self-checking bench for ram_line_server
module tb_ram_line_server;
    localparam int LAT = 4;
    localparam int AW  = 11;
    typedef logic [0:31][7:0] line_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
    logic [AW-1:0] req_addr = '0;
    line_t         req_wdata = '0;
    logic          req_ready, resp_valid, resp_we;
    line_t         resp_rdata;
    logic [31:0]   read_count, write_count;

    logic          q_valid = 1'b0, q_we = 1'b0, p_ready = 1'b1;
    logic [AW-1:0] q_addr = '0;
    line_t         q_wdata = '0;
    logic          q_ready, p_valid, p_we;
    line_t         p_rdata;
    logic [31:0]   p_rc, p_wc;

    int            vectors = 0;
    int            miscompares = 0;
    int            exp_rd = 0;
    int            exp_wr = 0;
    logic [7:0]    model_mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    ram_line_server #(.LATENCY(LAT), .ADDR_W(AW)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_we(resp_we), .resp_rdata(resp_rdata), .read_count(read_count), .write_count(write_count)
    );

    ram_line_server #(.LATENCY(1), .ADDR_W(AW)) u_lat1 (
        .clk(clk), .rst(rst), .req_valid(q_valid), .req_ready(q_ready), .req_we(q_we),
        .req_addr(q_addr), .req_wdata(q_wdata), .resp_valid(p_valid), .resp_ready(p_ready),
        .resp_we(p_we), .resp_rdata(p_rdata), .read_count(p_rc), .write_count(p_wc)
    );

    function automatic line_t model_line(input logic [AW-1:0] a);
        line_t l;
        int base = int'(a) & ~31;
        for (int k = 0; k < 32; k++) l[k] = model_mem[base + k];
        return l;
    endfunction

    function automatic line_t rand_line();
        line_t l;
        for (int k = 0; k < 32; k++) l[k] = 8'($urandom);
        return l;
    endfunction

    task automatic issue(input logic we, input logic [AW-1:0] a, input line_t wd, output line_t exp);
        int t = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
        while (!req_ready && t < 200) begin @(negedge clk); t++; end
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL accept_timeout req_ready=%b required 1", req_ready);
        end
        @(posedge clk);
        exp = we ? wd : model_line(a);
        if (we) for (int k = 0; k < 32; k++) model_mem[(int'(a) & ~31) + k] = wd[k];
    endtask

    task automatic wait_resp(input int exp_lat);
        int k = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while (!resp_valid && k < 300) begin @(negedge clk); k++; end
        vectors++;
        if (k != exp_lat) begin
            miscompares++;
            $display("FAIL latency got %0d cycles required %0d", k, exp_lat);
        end
    endtask

    task automatic finish_resp(input int stall, input logic we, input line_t exp);
        vectors++;
        if (resp_we !== we || resp_rdata !== exp) begin
            miscompares++;
            $display("FAIL resp_data got we=%b %h required we=%b %h", resp_we, resp_rdata, we, exp);
        end
        resp_ready = 1'b0;
        repeat (stall) begin
            req_valid = 1'($urandom);
            req_addr  = AW'($urandom);
            @(negedge clk);
            vectors++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== exp ||
                read_count !== 32'(exp_rd) || write_count !== 32'(exp_wr)) begin
                miscompares++;
                $display("FAIL stall_hold got rv=%b rr=%b rc=%0d wc=%0d required rv=1 rr=0 rc=%0d wc=%0d",
                         resp_valid, req_ready, read_count, write_count, exp_rd, exp_wr);
            end
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        if (we) exp_wr++; else exp_rd++;
        vectors++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 ||
            read_count !== 32'(exp_rd) || write_count !== 32'(exp_wr)) begin
            miscompares++;
            $display("FAIL transfer got rv=%b rr=%b rc=%0d wc=%0d required rv=0 rr=1 rc=%0d wc=%0d",
                     resp_valid, req_ready, read_count, write_count, exp_rd, exp_wr);
        end
    endtask

    task automatic txn(input logic we, input logic [AW-1:0] a, input line_t wd, input int stall);
        line_t e;
        issue(we, a, wd, e);
        wait_resp(LAT);
        finish_resp(stall, we, e);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_we !== 1'b0 || resp_rdata !== '0 ||
            read_count !== 32'd0 || write_count !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_values got rr=%b rv=%b we=%b rc=%0d wc=%0d required rr=1 rv=0 we=0 rc=0 wc=0",
                     req_ready, resp_valid, resp_we, read_count, write_count);
        end
        rst = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [10];
        int acc = 0, rsp = 0, cyc = 0, last = -1;
        logic sw = 1'b0;
        for (int i = 0; i < 10; i++) addrs[i] = AW'($urandom);
        @(negedge clk);
        q_valid = 1'b1; q_addr = addrs[0];
        while (rsp < 10 && cyc < 200) begin
            if (sw) begin
                if (acc < 10) q_addr = addrs[acc]; else q_valid = 1'b0;
                sw = 1'b0;
            end
            if (p_valid) begin
                vectors++;
                if (p_rdata !== model_line(addrs[rsp])) begin
                    miscompares++;
                    $display("FAIL b2b_data[%0d] got %h required %h", rsp, p_rdata, model_line(addrs[rsp]));
                end
                rsp++;
            end
            if (q_ready && q_valid) begin
                if (last >= 0) begin
                    vectors++;
                    if (cyc - last != 3) begin
                        miscompares++;
                        $display("FAIL b2b_spacing got %0d required 3", cyc - last);
                    end
                end
                last = cyc; acc++; sw = 1'b1;
            end
            @(negedge clk); cyc++;
        end
        q_valid = 1'b0;
        vectors++;
        if (p_rc !== 32'd10 || p_wc !== 32'd0) begin
            miscompares++;
            $display("FAIL b2b_count got rc=%0d wc=%0d required rc=10 wc=0", p_rc, p_wc);
        end
    endtask

    task automatic test_fill();
        txn(1'b0, 11'h150, '0, 0);
    endtask

    task automatic test_writeback();
        line_t wd;
        for (int k = 0; k < 32; k++) wd[k] = 8'(8'hE0 + k);
        txn(1'b1, 11'h150, wd, 0);
        txn(1'b0, 11'h15F, '0, 0);
    endtask

    task automatic test_stall();
        txn(1'b0, AW'($urandom), '0, 10);
    endtask

    task automatic test_async_reset();
        line_t e;
        issue(1'b0, 11'h2A3, '0, e);
        @(negedge clk); req_valid = 1'b0;
        @(posedge clk); #2; rst = 1'b0; #1;
        vectors++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_we !== 1'b0 || resp_rdata !== '0 ||
            read_count !== 32'd0 || write_count !== 32'd0) begin
            miscompares++;
            $display("FAIL async_reset got rr=%b rv=%b we=%b rc=%0d wc=%0d required rr=1 rv=0 we=0 rc=0 wc=0",
                     req_ready, resp_valid, resp_we, read_count, write_count);
        end
        exp_rd = 0; exp_wr = 0;
        @(negedge clk); rst = 1'b1;
        issue(1'b1, 11'h0C0, rand_line(), e);
        @(negedge clk); req_valid = 1'b0;
        #2; rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        txn(1'b0, 11'h0C7, '0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            logic we = 1'($urandom);
            logic [AW-1:0] a = AW'(($urandom_range(0, 7) << 5) | $urandom_range(0, 31));
            txn(we, a, rand_line(), $urandom_range(0, 3));
        end
    endtask

    task automatic test_cache();
        int lru [$];
        int misses = 0;
        int base = exp_rd;
        for (int rep = 0; rep < 2; rep++) begin
            for (int tg = 1; tg <= 5; tg++) begin
                int hit = -1;
                foreach (lru[i]) if (lru[i] == tg) hit = i;
                if (hit >= 0) begin
                    lru.delete(hit);
                end else begin
                    misses++;
                    if (lru.size() == 4) void'(lru.pop_front());
                    txn(1'b0, AW'((tg * 8 + 5) * 32), '0, 0);
                end
                lru.push_back(tg);
            end
        end
        vectors++;
        if (read_count !== 32'(base + misses)) begin
            miscompares++;
            $display("FAIL cache_misses got %0d required %0d", read_count, base + misses);
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) model_mem[a] = 8'(a);
        test_reset();
        test_back_to_back();
        test_fill();
        test_writeback();
        test_stall();
        test_async_reset();
        test_random();
        test_cache();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
